julia_iter_ctrl: RTL and testbench
==================================

# julia_iter_ctrl

Sequencer for one Julia-set pixel iteration, z(n+1) = z(n)^2 + c, in signed fixed point (FRACTIONAL fractional bits, INTEGRAL integer bits, two's complement). It time-shares a single instance of the existing fixed_multiplication block across the three products each iteration needs: zr*zr, zi*zi and zr*zi. It also counts iterations, tests for escape (|z|^2 > 4.0) and reports the result. It sits inside Julia_Worker between the pixel dispatcher and the result writer.

## Interface
- FRACTIONAL, 11, fractional bits of every fixed-point value
- INTEGRAL, 11, integer bits, sign included; W = FRACTIONAL + INTEGRAL
- ITER_W, 8, width of the iteration limit and the iteration counter
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- c_re, c_im  in  W  constant c; captured on an accepted start
- z0_re, z0_im  in  W  initial z; captured on an accepted start
- max_iter  in  ITER_W  iteration limit; captured on an accepted start
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse; the result outputs are valid in that cycle
- escaped  out  1  1 = escape detected, 0 = limit reached
- iter_count  out  ITER_W  iterations completed before the escape or at the limit

## Operation
- States: IDLE, MUL_RR, MUL_II, MUL_RI, UPDATE, DONE.
- IDLE + start:
  - capture c, z, max_iter; clear the counter.
  - If max_iter == 0, go to DONE with escaped=0 and iter_count=0.
  - Otherwise go to MUL_RR.
- MUL_RR, MUL_II, MUL_RI:
  - The multiplier operand mux selects (zr,zr), (zi,zi) and (zr,zi) respectively.
  - The W-bit product is registered into rr, ii and ri.
- UPDATE:
  - mag = rr + ii, computed in W+1 bits signed.
  - If mag > 4.0 (4 << FRACTIONAL): escaped=1, iter_count = counter, go to DONE. z is not updated.
  - Otherwise:
    - zr <= rr - ii + c_re
    - zi <= (ri << 1) + c_im
    - counter++
    - If the new counter == max_iter: escaped=0, go to DONE.
    - Otherwise go to MUL_RR.
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic:
  - The z update truncates to W bits with two's-complement wrap. No saturation.
  - mag == 4.0 exactly is not an escape.
- start while not in IDLE is ignored, with no queuing.
- escaped and iter_count hold their values until the next accepted start.

## Timing
- Reset values:
  - state IDLE; ready=1, done=0, escaped=0, iter_count=0.
  - z, c, rr, ii, ri and counter all 0.
- Reset mid-operation abandons the computation, produces no done pulse, and takes effect on the next edge.
- Let start be sampled at the edge ending cycle 0:
  - Escape detected on z(k): done is high in cycle 4k+5, with iter_count=k.
  - No escape: done is high in cycle 4*max_iter+1, with iter_count=max_iter.
  - max_iter == 0: done is high in cycle 1.
- ready is low from cycle 1 through the done cycle. start is accepted again in the cycle after done.
- The multiplier is combinational; each MUL state is exactly one cycle.

## Structure
- Package julia_pkg holds:
  - the state enum
  - ESCAPE_SQ = 4 << FRACTIONAL
  - default FRACTIONAL/INTEGRAL localparams shared with the other Julia_Worker blocks
- Exactly one sub-module: fixed_multiplication, instantiated once with matching FRACTIONAL/INTEGRAL and an operand mux in front of it.
- Everything else (FSM, counter, z/c registers, adder/compare) lives in julia_iter_ctrl.

## Test plan
- c=0, z0=0, max_iter=10 -> done in cycle 41, escaped=0, iter_count=10.
- c=0, z0=(3.0,0) (z0_re=6144) -> done in cycle 5, escaped=1, iter_count=0.
- c=(1.0,0) (2048), z0=0, max_iter=20: z sequence 0, 1, 2, 5 -> escape on z3; done in cycle 17, escaped=1, iter_count=3.
- Boundary: c=0, z0=(2.0,0), max_iter=5 -> mag 4.0 is not an escape, then 16.0 escapes; done in cycle 9, iter_count=1, escaped=1.
- max_iter=0 -> done in cycle 1, escaped=0, iter_count=0. Also check start pulses during a run are ignored: exactly one done per accepted start.
- rst asserted in cycle 6 of a 10-iteration run -> next cycle: ready=1, escaped=0, iter_count=0, no done pulse. A new start then completes with the correct result.

Source files
------------

// File: rtl/julia_pkg.sv
// Shared definitions for the Julia_Worker blocks: fixed-point defaults,
// the iteration-controller state encoding and the escape threshold.
package julia_pkg;

  localparam int JULIA_FRACTIONAL = 11;
  localparam int JULIA_INTEGRAL   = 11;
  localparam int JULIA_ITER_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    MUL_RR,
    MUL_II,
    MUL_RI,
    UPDATE,
    DONE
  } state_e;

  // |z|^2 escape limit (4.0) for a given number of fractional bits.
  function automatic longint escape_sq(input int frac);
    return longint'(4) << frac;
  endfunction

  localparam longint ESCAPE_SQ = escape_sq(JULIA_FRACTIONAL);

endpackage

// File: rtl/fixed_multiplication.sv
// Combinational signed fixed-point multiply: full product shifted back by
// FRACTIONAL bits and truncated (two's-complement wrap) to the operand width.
module fixed_multiplication
  import julia_pkg::*;
#(
  parameter int FRACTIONAL = JULIA_FRACTIONAL,
  parameter int INTEGRAL   = JULIA_INTEGRAL
) (
  input  logic signed [FRACTIONAL+INTEGRAL-1:0] a_i,
  input  logic signed [FRACTIONAL+INTEGRAL-1:0] b_i,
  output logic signed [FRACTIONAL+INTEGRAL-1:0] p_o
);

  localparam int W = FRACTIONAL + INTEGRAL;

  logic signed [2*W-1:0] prod;

  assign prod = a_i * b_i;
  assign p_o  = W'(prod >>> FRACTIONAL);

endmodule

// File: rtl/julia_iter_ctrl.sv
// Julia-set pixel iteration sequencer: one shared multiplier computes
// zr*zr, zi*zi, zr*zi over three cycles, then a single update/escape cycle.
module julia_iter_ctrl
  import julia_pkg::*;
#(
  parameter int FRACTIONAL = JULIA_FRACTIONAL,
  parameter int INTEGRAL   = JULIA_INTEGRAL,
  parameter int ITER_W     = JULIA_ITER_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic signed [FRACTIONAL+INTEGRAL-1:0] c_re,
  input  logic signed [FRACTIONAL+INTEGRAL-1:0] c_im,
  input  logic signed [FRACTIONAL+INTEGRAL-1:0] z0_re,
  input  logic signed [FRACTIONAL+INTEGRAL-1:0] z0_im,
  input  logic        [ITER_W-1:0]              max_iter,
  output logic                                  ready,
  output logic                                  done,
  output logic                                  escaped,
  output logic        [ITER_W-1:0]              iter_count
);

  localparam int W = FRACTIONAL + INTEGRAL;
  localparam logic signed [W:0] ESC_LIMIT = (W+1)'(escape_sq(FRACTIONAL));

  state_e state_q, state_d;

  logic signed [W-1:0] zr_q, zr_d, zi_q, zi_d;
  logic signed [W-1:0] cr_q, cr_d, ci_q, ci_d;
  logic signed [W-1:0] rr_q, rr_d, ii_q, ii_d, ri_q, ri_d;
  logic [ITER_W-1:0]   cnt_q, cnt_d, max_q, max_d;
  logic                esc_q, esc_d;

  logic signed [W-1:0] mul_a, mul_b, mul_p;
  logic signed [W:0]   mag;
  logic [ITER_W-1:0]   cnt_inc;

  // Sign-extend by one bit so rr + ii cannot overflow before the compare.
  assign mag     = {rr_q[W-1], rr_q} + {ii_q[W-1], ii_q};
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    mul_a = zr_q;
    mul_b = zr_q;
    case (state_q)
      MUL_II: begin
        mul_a = zi_q;
        mul_b = zi_q;
      end
      MUL_RI: begin
        mul_a = zr_q;
        mul_b = zi_q;
      end
      default: ;
    endcase
  end

  fixed_multiplication #(
    .FRACTIONAL(FRACTIONAL),
    .INTEGRAL  (INTEGRAL)
  ) u_mul (
    .a_i(mul_a),
    .b_i(mul_b),
    .p_o(mul_p)
  );

  always_comb begin
    state_d = state_q;
    zr_d    = zr_q;
    zi_d    = zi_q;
    cr_d    = cr_q;
    ci_d    = ci_q;
    rr_d    = rr_q;
    ii_d    = ii_q;
    ri_d    = ri_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    esc_d   = esc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cr_d    = c_re;
          ci_d    = c_im;
          zr_d    = z0_re;
          zi_d    = z0_im;
          max_d   = max_iter;
          cnt_d   = '0;
          esc_d   = 1'b0;
          state_d = (max_iter == '0) ? DONE : MUL_RR;
        end
      end
      MUL_RR: begin
        rr_d    = mul_p;
        state_d = MUL_II;
      end
      MUL_II: begin
        ii_d    = mul_p;
        state_d = MUL_RI;
      end
      MUL_RI: begin
        ri_d    = mul_p;
        state_d = UPDATE;
      end
      UPDATE: begin
        if (mag > ESC_LIMIT) begin
          esc_d   = 1'b1;
          state_d = DONE;
        end else begin
          zr_d    = rr_q - ii_q + cr_q;
          zi_d    = (ri_q <<< 1) + ci_q;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == max_q) ? DONE : MUL_RR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      zr_q    <= '0;
      zi_q    <= '0;
      cr_q    <= '0;
      ci_q    <= '0;
      rr_q    <= '0;
      ii_q    <= '0;
      ri_q    <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
      esc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      zr_q    <= zr_d;
      zi_q    <= zi_d;
      cr_q    <= cr_d;
      ci_q    <= ci_d;
      rr_q    <= rr_d;
      ii_q    <= ii_d;
      ri_q    <= ri_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      esc_q   <= esc_d;
    end
  end

  assign ready      = (state_q == IDLE);
  assign done       = (state_q == DONE);
  assign escaped    = esc_q;
  assign iter_count = cnt_q;

endmodule

// File: tb/tb_julia_iter_ctrl.sv
// Scoreboard bench for julia_iter_ctrl: the driver queues the expected result
// and done latency per accepted start, a monitor checks each done pulse.
module tb_julia_iter_ctrl;

  localparam int W = 22;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic signed [W-1:0] c_re = '0, c_im = '0, z0_re = '0, z0_im = '0;
  logic [7:0]          max_iter = '0;
  logic                ready, done, escaped;
  logic [7:0]          iter_count;

  typedef struct {
    int start_cyc;
    int done_rel;
    bit esc;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  julia_iter_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .c_re      (c_re),
    .c_im      (c_im),
    .z0_re     (z0_re),
    .z0_im     (z0_im),
    .max_iter  (max_iter),
    .ready     (ready),
    .done      (done),
    .escaped   (escaped),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: actual=1 required=0 (cyc %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc - e.start_cyc + 1, e.done_rel);
        check("escaped", int'(escaped), int'(e.esc));
        check("iter_count", int'(iter_count), e.cnt);
        $display("txn: done at cycle %0d escaped=%0d iter_count=%0d (expect cycle %0d esc %0d cnt %0d)",
                 cyc - e.start_cyc + 1, escaped, iter_count, e.done_rel, e.esc, e.cnt);
      end
    end
  end

  task automatic issue(input int cr, input int ci, input int zr, input int zi, input int mi);
    c_re     = W'(cr);
    c_im     = W'(ci);
    z0_re    = W'(zr);
    z0_im    = W'(zi);
    max_iter = 8'(mi);
    start    = 1'b1;
  endtask

  task automatic run_vec(input string name, input int cr, input int ci, input int zr,
                         input int zi, input int mi, input int done_rel, input bit esc,
                         input int cnt, input bit spurious);
    exp_t e;
    check({name, "_ready_before"}, int'(ready), 1);
    e.start_cyc = cyc + 1;
    e.done_rel  = done_rel;
    e.esc       = esc;
    e.cnt       = cnt;
    sb.push_back(e);
    issue(cr, ci, zr, zi, mi);
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) check({name, "_ready_busy"}, int'(ready), 0);
      if (spurious && (i == 3 || i == 20)) start = 1'b1;
      if (sb.size() == 0) break;
      if (i == 400) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: actual=no_done required=done", name);
        sb.delete();
      end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_escaped", int'(escaped), 0);
    check("rst_iter_count", int'(iter_count), 0);
    rst = 1'b0;
    @(negedge clk);

    // name, c_re, c_im, z0_re, z0_im, max_iter, done cycle, escaped, iter_count
    run_vec("zero_limit10", 0, 0, 0, 0, 10, 41, 1'b0, 10, 1'b1);
    run_vec("z0_3p0", 0, 0, 6144, 0, 8, 5, 1'b1, 0, 1'b0);
    run_vec("c_1p0", 2048, 0, 0, 0, 20, 17, 1'b1, 3, 1'b0);
    run_vec("mag_eq_4", 0, 0, 4096, 0, 5, 9, 1'b1, 1, 1'b0);
    run_vec("max_zero", 0, 0, 0, 0, 0, 1, 1'b0, 0, 1'b0);
    run_vec("c_imag", 0, 2048, 0, 0, 3, 13, 1'b0, 3, 1'b0);

    // Reset in cycle 6 of a 10-iteration run: abandoned, no done pulse.
    issue(0, 0, 0, 0, 10);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", int'(ready), 1);
    check("midrst_escaped", int'(escaped), 0);
    check("midrst_iter_count", int'(iter_count), 0);
    check("midrst_done", int'(done), 0);
    repeat (45) @(negedge clk);
    run_vec("after_rst", 2048, 0, 0, 0, 20, 17, 1'b1, 3, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
